hazard_ctrl: RTL

Pipeline hazard controller for the EX stage. It generates the forwarding selects for both ALU operands and the load-use stall/bubble. It sequences a multi-cycle MUL by holding the front end while the ALU is occupied, and flushes wrong-path instructions after a taken branch. It sits beside the ID/EX, EX/DM and DM/WB registers and drives `stall_flag` to the fetch, decode and execute stages.

---
 rtl/hazard_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module   : hazard_ctrl
// Purpose  : EX-stage pipeline hazard controller. Generates ALU operand
//            forwarding selects, detects load-use hazards (stall + bubble),
//            sequences multi-cycle MUL by freezing the front end, and
//            flushes wrong-path instructions after a taken branch.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            id_*/ex_*/dm_*/wb_*   - pipeline register addresses and controls
//            branch_taken          - registered taken-branch pulse from EX
//            forward_a/forward_b   - operand selects (00 RF, 01 EX/DM, 10 DM/WB)
//            stall_flag            - freeze PC, IF/ID and ID/EX
//            flush_if/flush_id     - zero IF/ID, bubble ID/EX
//            mul_busy/mul_result_valid - MUL occupancy / final-result strobe
//            stall_count/flush_count   - saturating performance counters
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MUL_LAT   = 3,    // cycles a MUL occupies EX, 1..16
    parameter int FLUSH_CYC = 2     // flush cycles per taken branch, 1..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  ex_rs_addr,
    input  logic [4:0]  ex_rt_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_is_mul,
    input  logic [4:0]  dm_rd_addr,
    input  logic        dm_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        stall_flag,
    output logic        flush_if,
    output logic        flush_id,
    output logic        mul_busy,
    output logic        mul_result_valid,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // FSM encoding
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MUL_BUSY = 2'd1;
    localparam logic [1:0] c_FLUSH    = 2'd2;

    // The cycle that starts a MUL or a flush is the first of its run, so the
    // down-counter is loaded with length-2 and the final cycle sees cnt==0.
    localparam logic [3:0] c_MUL_RELOAD   = 4'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam logic [3:0] c_FLUSH_RELOAD = 4'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);
    // A single-cycle flush is fully covered by the branch cycle itself.
    localparam logic [1:0] c_FLUSH_NEXT   = (FLUSH_CYC > 1) ? c_FLUSH : c_IDLE;
    localparam logic       c_MUL_MULTI    = (MUL_LAT > 1);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic        w_load_use;
    logic        w_mul_start;
    logic        w_mul_single;
    logic        w_stall;
    logic        w_flush_if;
    logic        w_flush_id;
    logic        w_mul_busy;
    logic        w_mul_valid;

    // DM result is younger than WB, so it wins; r0 is hard-wired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       dm_we,
        input logic [4:0] dm_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (dm_we && (dm_rd != 5'd0) && (dm_rd == src)) begin
            return 2'b01;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(ex_rs_addr, dm_reg_write, dm_rd_addr,
                             wb_reg_write, wb_rd_addr);
    assign w_fwd_b = fwd_sel(ex_rt_addr, dm_reg_write, dm_rd_addr,
                             wb_reg_write, wb_rd_addr);

    assign w_load_use   = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
                          ((ex_rd_addr == id_rs_addr) || (ex_rd_addr == id_rt_addr));
    assign w_mul_start  = ex_valid && ex_is_mul && c_MUL_MULTI;
    assign w_mul_single = ex_valid && ex_is_mul && !c_MUL_MULTI;

    // Next-state and per-cycle control; priority branch > mul > load-use.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_stall     = 1'b0;
        w_flush_if  = 1'b0;
        w_flush_id  = 1'b0;
        w_mul_busy  = 1'b0;
        w_mul_valid = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (branch_taken) begin
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                    state_d    = c_FLUSH_NEXT;
                    cnt_d      = c_FLUSH_RELOAD;
                end else if (w_mul_start) begin
                    w_stall    = 1'b1;
                    w_mul_busy = 1'b1;
                    state_d    = c_MUL_BUSY;
                    cnt_d      = c_MUL_RELOAD;
                end else if (w_load_use) begin
                    // The load moves on next cycle, so one bubble suffices.
                    w_stall    = 1'b1;
                    w_flush_id = 1'b1;
                end else if (w_mul_single) begin
                    w_mul_valid = 1'b1;
                end
            end

            c_MUL_BUSY: begin
                if (branch_taken) begin
                    // The MUL is on the wrong path: drop it and flush.
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                    state_d    = c_FLUSH_NEXT;
                    cnt_d      = c_FLUSH_RELOAD;
                end else begin
                    w_mul_busy = 1'b1;
                    w_stall    = (cnt_q != 4'd0);
                    if (cnt_q == 4'd0) begin
                        w_mul_valid = 1'b1;
                        state_d     = c_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            c_FLUSH: begin
                w_flush_if = 1'b1;
                w_flush_id = 1'b1;
                if (branch_taken) begin
                    cnt_d = c_FLUSH_RELOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = c_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Every accepted taken branch counts, whatever state it arrives in.
    assign stall_cnt_d = (w_stall && (stall_cnt_q != c_CNT_MAX)) ?
                         stall_cnt_q + 16'd1 : stall_cnt_q;
    assign flush_cnt_d = (branch_taken && (flush_cnt_q != c_CNT_MAX)) ?
                         flush_cnt_q + 16'd1 : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // All outputs are forced low while reset is held, counters included.
    assign forward_a        = reset ? 2'b00 : w_fwd_a;
    assign forward_b        = reset ? 2'b00 : w_fwd_b;
    assign stall_flag       = !reset && w_stall;
    assign flush_if         = !reset && w_flush_if;
    assign flush_id         = !reset && w_flush_id;
    assign mul_busy         = !reset && w_mul_busy;
    assign mul_result_valid = !reset && w_mul_valid;
    assign stall_count      = reset ? 16'd0 : stall_cnt_q;
    assign flush_count      = reset ? 16'd0 : flush_cnt_q;

endmodule

`default_nettype wire
